rsc_bank: RTL
=============

# rsc_bank

Parametrised bank of N_CH recursive systematic convolutional (RSC) encoders sharing one clock, one framing FSM and one valid/ready input handshake. It is the successor to the fixed two-instance RSC arrangement used in the turbo-encoder datapath. Generator polynomials, memory depth and frame length are configurable, and each frame can optionally end with trellis-termination tail bits. It sits between the bit source and the interleaver/puncturer stage.

## Interface
- N_CH, 2, number of parallel encoder channels (≥1)
- MEM, 3, encoder memory (state bits per channel, ≥1)
- G_FB, 4'b1101, feedback polynomial [MEM:0]; bit i = coefficient of D^i; bit 0 must be 1 (default 1+D^2+D^3)
- G_FF, 4'b1011, parity polynomial [MEM:0], same encoding (default 1+D+D^3)
- FRAME_LEN, 40, data bits per frame per channel (≥2)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input beat offered
- in_ready  out  1  bank accepts a beat
- in_data  in  N_CH  one data bit per channel
- mode  in  1  0 = terminated frame, 1 = truncated frame; sampled on first beat of each frame
- x_out  out  N_CH  systematic bit (data or tail)
- z_out  out  N_CH  parity bit
- valid_out  out  1  x_out/z_out valid
- tail_out  out  1  current output is a tail bit
- sof_out  out  1  first output of frame
- eof_out  out  1  last output of frame

## Operation
- Per-channel state s[1..MEM], s[1] newest. fb = XOR over i=1..MEM of G_FB[i]&s[i]; a = u ^ fb; z = (G_FF[0]&a) ^ XOR_i (G_FF[i]&s[i]); x = u; next state s[1]=a, s[i]=s[i-1].
- FSM states: DATA, TAIL. Reset → DATA, bit_cnt=0, all channel states 0.
- DATA: in_ready=1. Beat accepted when in_valid&in_ready; u=in_data[ch]; bit_cnt increments. On the beat with bit_cnt==0, mode is latched as frame_mode and sof_out is set on the matching output.
- On the accepted beat with bit_cnt==FRAME_LEN-1: bit_cnt→0. If frame_mode=0, go to TAIL. If frame_mode=1, stay in DATA, set eof_out on that output and clear all channel states to 0 on the same edge.
- TAIL: in_ready=0. For MEM cycles, u=fb per channel, so a=0. tail_cnt counts 0..MEM-1. On the last tail cycle, eof_out is set, the state reaches all-zero and the FSM returns to DATA.
- When in_valid is low in DATA, state and counters hold and valid_out=0 on the next cycle.
- mode changes mid-frame are ignored.
- No output backpressure; the consumer must accept every valid_out cycle.

## Timing
- Reset value of all outputs is 0 (x_out, z_out, valid_out, tail_out, sof_out, eof_out). in_ready is a decode of DATA and reads 1 from the first cycle after reset deasserts. Beats presented while reset=1 are ignored.
- Latency: beat accepted at edge t produces registered outputs with valid_out=1 visible after edge t+1.
- Terminated frame: last data beat at t; TAIL occupies cycles t+1..t+MEM; tail outputs appear after edges t+2..t+MEM+1; in_ready returns to 1 at cycle t+MEM+1.
- Truncated frame: back-to-back frames at full rate with no bubble.
- Reset mid-frame or mid-tail: the partial frame is discarded, the FSM and state are cleared, and no eof_out is produced.
- Counter widths: bit_cnt is $clog2(FRAME_LEN) bits; tail_cnt is $clog2(MEM+1) bits.

## Configuration
- RSC_BANK_TAIL_EN defined: TAIL state, tail_cnt and termination logic are compiled in, and mode behaves as described above.
- RSC_BANK_TAIL_EN undefined: the TAIL state is removed, mode is ignored, every frame is truncated, and tail_out is tied to 0.

## Test plan
All scenarios use default polynomials, MEM=3 and FRAME_LEN=4 unless stated.
- Impulse, terminated: ch0 data 1,0,0,0, mode=0 → z=1,1,1,1. Tail x=1,0,1 and z=1,1,1 with tail_out=1. eof_out on the 7th output; final state 000; in_ready low for 3 cycles.
- All-zero frame, mode=0: all x/z=0 including tail; sof_out on the 1st output, eof_out on the 7th.
- Truncated back-to-back: in_valid held high for two frames with mode=1 → 8 consecutive valid_out cycles, in_ready never low. The second frame's impulse response equals the first's, confirming state clearing.
- Gaps: impulse frame with in_valid low 2 cycles between each beat → same x/z sequence; valid_out low during gaps.
- Reset mid-tail: assert reset at the 2nd tail cycle → all outputs 0 next cycle, in_ready=1 after release. The following all-zero frame yields zero parity.
- Multi-channel: N_CH=4, channels fed 1000/0000/1000/1111 → channels 0 and 2 produce identical outputs, channel 1 all zero, channel 3 matches the reference model.

Source files
------------

// File: rtl/rsc_bank.sv
// rsc_bank: N_CH parallel RSC encoders sharing one framing FSM and one valid/ready input.
// Define RSC_BANK_TAIL_EN to compile in trellis termination (TAIL state, mode-selected frames).
module rsc_bank #(
   parameter int             N_CH      = 2,
   parameter int             MEM       = 3,
   parameter logic [MEM:0]   G_FB      = 4'b1101,
   parameter logic [MEM:0]   G_FF      = 4'b1011,
   parameter int             FRAME_LEN = 40
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_CH-1:0] in_data,
   input  logic            mode,
   output logic [N_CH-1:0] x_out,
   output logic [N_CH-1:0] z_out,
   output logic            valid_out,
   output logic            tail_out,
   output logic            sof_out,
   output logic            eof_out
);

   localparam int             BW       = $clog2(FRAME_LEN);
   localparam int             TW       = $clog2(MEM + 1);
   localparam logic [BW-1:0]  LAST_BIT = BW'(FRAME_LEN - 1);
   localparam logic [MEM-1:0] FB_TAPS  = G_FB[MEM:1];
   localparam logic [MEM-1:0] FF_TAPS  = G_FF[MEM:1];

   logic            accept;
   logic            first_beat;
   logic            last_beat;
   logic            trunc_mode;
   logic            tail_step;
   logic            last_tail;
   logic            step;
   logic [BW-1:0]   bit_cnt_reg;
   logic [N_CH-1:0] x_next;
   logic [N_CH-1:0] z_next;

   assign accept     = in_valid & in_ready;
   assign first_beat = accept && (bit_cnt_reg == '0);
   assign last_beat  = accept && (bit_cnt_reg == LAST_BIT);
   assign step       = accept | tail_step;

`ifdef RSC_BANK_TAIL_EN
   typedef enum logic {DATA = 1'b0, TAIL = 1'b1} state_t;

   state_t        state_reg;
   state_t        state_next;
   logic [TW-1:0] tail_cnt_reg;
   logic          frame_mode_reg;

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= DATA;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         DATA: if (last_beat && !trunc_mode) state_next = TAIL;
         TAIL: if (last_tail) state_next = DATA;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == DATA);
      tail_step = (state_reg == TAIL);
   end

   // mode is only honoured on the first beat; later beats see the latched copy
   assign trunc_mode = first_beat ? mode : frame_mode_reg;
   assign last_tail  = tail_step && (tail_cnt_reg == TW'(MEM - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tail_cnt_reg   <= '0;
         frame_mode_reg <= 1'b0;
      end else begin
         if (first_beat)
            frame_mode_reg <= mode;
         if (tail_step)
            tail_cnt_reg <= last_tail ? '0 : tail_cnt_reg + TW'(1);
      end
   end
`else
   // without termination every frame is truncated and mode has no effect
   assign in_ready   = 1'b1;
   assign tail_step  = 1'b0;
   assign last_tail  = 1'b0;
   assign trunc_mode = mode | 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         bit_cnt_reg <= '0;
      else if (accept)
         bit_cnt_reg <= last_beat ? '0 : bit_cnt_reg + BW'(1);
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [MEM-1:0] st_reg;
         logic           fb;
         logic           u;
         logic           a;
         logic           z;

         // st_reg[0] holds s[1] (newest), st_reg[MEM-1] holds s[MEM]
         always_comb begin
            fb = ^(st_reg & FB_TAPS);
            u  = tail_step ? fb : in_data[gi];
            a  = u ^ fb;
            z  = (G_FF[0] & a) ^ (^(st_reg & FF_TAPS));
         end

         assign x_next[gi] = u;
         assign z_next[gi] = z;

         always_ff @(posedge clk) begin
            if (reset || (last_beat && trunc_mode))
               st_reg <= '0;
            else if (step)
               st_reg <= (st_reg << 1) | MEM'(a);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         x_out     <= '0;
         z_out     <= '0;
         valid_out <= 1'b0;
         tail_out  <= 1'b0;
         sof_out   <= 1'b0;
         eof_out   <= 1'b0;
      end else begin
         x_out     <= step ? x_next : '0;
         z_out     <= step ? z_next : '0;
         valid_out <= step;
         tail_out  <= tail_step;
         sof_out   <= first_beat;
         eof_out   <= (last_beat & trunc_mode) | last_tail;
      end
   end

endmodule
